// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM hazard sources in,
// register enables / flush / bubble / status out.
// master: pipeline side (drives sources); slave: hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_memRead;
    logic [4:0]       ex_RegAdd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_memRead, ex_RegAdd, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
        input  ifid_flush, idex_bubble, memwb_bubble,
        input  mem_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_memRead, ex_RegAdd, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
        output ifid_flush, idex_bubble, memwb_bubble,
        output mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use bubble, branch flush, memory freeze,
// memory-timeout flag and saturating stall counter.
// Ports: clk, rst (sync, active-high), hz (hazard_ctrl_if.slave bundle).
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic pc_write;

    assign freeze  = hz.mem_req & ~hz.mem_ready;
    assign rs1_hit = hz.id_uses_rs1 & (hz.ex_RegAdd == hz.id_rs1);
    assign rs2_hit = hz.id_uses_rs2 & (hz.ex_RegAdd == hz.id_rs2);
    assign load_use = hz.ex_memRead & (hz.ex_RegAdd != 5'd0)
                    & (rs1_hit | rs2_hit);

    // Control outputs: reset > freeze > branch > load-use > default.
    always_comb begin
        pc_write        = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.idex_write   = 1'b1;
        hz.exmem_write  = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.memwb_bubble = 1'b0;
        if (rst) begin
            pc_write        = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_write  = 1'b0;
            hz.ifid_flush   = 1'b1;
            hz.idex_bubble  = 1'b1;
            hz.memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write        = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_write  = 1'b0;
            hz.memwb_bubble = 1'b1;
        end else if (hz.ex_branch_taken) begin
            // Squashes the dependent instruction, so load-use is moot.
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write       = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    assign hz.pc_write  = pc_write;
    assign hz.mem_err   = mem_err_q;
    assign hz.stall_cnt = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (freeze) state_d = MEM_WAIT;
            MEM_WAIT: if (hz.mem_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        wait_cnt_d  = '0;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                  : wait_cnt_q + 1'b1;
            // The freeze cycle that finds the counter full is the
            // TIMEOUT-th consecutive one.
            if (wait_cnt_q == WAIT_MAX) mem_err_d = 1'b1;
        end
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) bus ();

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    typedef struct {
        int          idx;
        logic [6:0]  ctrl;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    // {pc, ifid, idex, exmem, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [6:0] DEF  = 7'b1111_000;
    localparam logic [6:0] RSTO = 7'b0000_111;
    localparam logic [6:0] FRZ  = 7'b0000_001;
    localparam logic [6:0] BR   = 7'b1111_110;
    localparam logic [6:0] LU   = 7'b0011_010;

    initial begin
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_memRead      = 1'b0;
        bus.ex_RegAdd       = '0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
    end

    task automatic vec(
        input logic       r,
        input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2,
        input logic       mr,  input logic [4:0] rd,
        input logic       br,
        input logic       req, input logic rdy,
        input logic [6:0] ec,  input logic ee,
        input int         en
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.id_rs1          = rs1;
        bus.id_uses_rs1     = u1;
        bus.id_rs2          = rs2;
        bus.id_uses_rs2     = u2;
        bus.ex_memRead      = mr;
        bus.ex_RegAdd       = rd;
        bus.ex_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
        vec_no++;
        e.idx  = vec_no;
        e.ctrl = ec;
        e.err  = ee;
        e.cnt  = en;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e = q.pop_front();
            act = {bus.pc_write, bus.ifid_write, bus.idex_write,
                   bus.exmem_write, bus.ifid_flush, bus.idex_bubble,
                   bus.memwb_bubble};
            n_run++;
            if (act !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl v%0d: got %b want %b",
                         e.idx, act, e.ctrl);
            end
            n_run++;
            if (bus.mem_err !== e.err) begin
                n_fail++;
                $display("FAIL mem_err v%0d: got %b want %b",
                         e.idx, bus.mem_err, e.err);
            end
            n_run++;
            if (bus.stall_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL stall_cnt v%0d: got %0d want %0d",
                         e.idx, bus.stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        int guard;
        //   rst rs1  u1 rs2  u2 mr rd  br req rdy  exp  err cnt
        vec(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RSTO, 0, 0);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, DEF,  0, 0);
        // load-use on rs1
        vec(0, 5'd5, 1, 5'd7, 1, 1, 5'd5, 0, 0, 0, LU,   0, 0);
        vec(0, 5'd5, 1, 5'd7, 1, 0, 5'd5, 0, 0, 0, DEF,  0, 1);
        // x0 destination, and match only on unused rs2
        vec(0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, DEF,  0, 1);
        vec(0, 5'd5, 1, 5'd7, 0, 1, 5'd7, 0, 0, 0, DEF,  0, 1);
        // load-use on used rs2
        vec(0, 5'd5, 1, 5'd7, 1, 1, 5'd7, 0, 0, 0, LU,   0, 1);
        // branch overrides load-use
        vec(0, 5'd5, 1, 5'd7, 1, 1, 5'd7, 1, 0, 0, BR,   0, 2);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, DEF,  0, 2);
        // 3-cycle memory wait, hazards ignored while frozen
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  0, 2);
        vec(0, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 1, 0, FRZ,  0, 3);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, FRZ,  0, 4);
        // release with a branch pending: acted on that cycle
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 1, BR,   0, 5);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, DEF,  0, 5);
        // timeout: six frozen cycles, flag after the fourth edge
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  0, 5);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  0, 6);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  0, 7);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  0, 8);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  1, 9);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  1, 10);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, DEF,  1, 11);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, DEF,  1, 11);
        // reset in the middle of a wait
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, FRZ,  1, 11);
        vec(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, RSTO, 1, 12);
        vec(1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 1, 0, RSTO, 0, 0);
        vec(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, DEF,  0, 0);
        // release cycle re-evaluates a held load-use
        vec(0, 5'd9, 1, 5'd0, 0, 1, 5'd9, 0, 1, 0, FRZ,  0, 0);
        vec(0, 5'd9, 1, 5'd0, 0, 1, 5'd9, 0, 1, 1, LU,   0, 1);
        vec(0, 5'd9, 1, 5'd0, 0, 0, 5'd9, 0, 0, 0, DEF,  0, 2);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        n_run++;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It is the producer-side complement of the EX-stage forwarding logic, and handles every hazard that forwarding cannot cover:
- load-use dependencies, by inserting one bubble;
- taken branches in EX, by flushing the two younger instructions;
- data-memory wait states, via a req/ready handshake that freezes the whole pipeline.

It also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.

## Interface
Parameters:
- `TIMEOUT`, 64: number of consecutive memory-wait cycles before `mem_err` is set (≥2).
- `CNT_W`, 32: width of `stall_cnt`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction actually reads that source.
- `ex_memRead`  in  1  instruction in EX is a load.
- `ex_RegAdd`  in  5  destination register of the EX instruction.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `mem_req`  in  1  MEM stage presents a data-memory access this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID register enable.
- `idex_write`  out  1  ID/EX register enable.
- `exmem_write`  out  1  EX/MEM register enable.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `idex_bubble`  out  1  load NOP into ID/EX.
- `memwb_bubble`  out  1  load NOP into MEM/WB.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  `CNT_W`  saturating count of cycles with `pc_write`=0.

## Operation
- **State machine:** `RUN`, `MEM_WAIT`. Reset state is `RUN`.
  - `RUN`→`MEM_WAIT` when `mem_req`=1 and `mem_ready`=0.
  - `MEM_WAIT`→`RUN` on the cycle `mem_ready`=1.
  - `MEM_WAIT`→`MEM_WAIT` otherwise. `mem_req` is held high by MEM while frozen, because EX/MEM is frozen.
- **Freeze**, with highest priority, asserted whenever `mem_req`=1 and `mem_ready`=0 (in either state):
  - `pc_write`, `ifid_write`, `idex_write`, `exmem_write` = 0;
  - `memwb_bubble`=1;
  - `ifid_flush`=0, `idex_bubble`=0.
  - A branch or load-use condition present during freeze is not acted on. It is re-evaluated on the release cycle.
- **Branch flush**, when not frozen and `ex_branch_taken`=1:
  - `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1;
  - all other enables = 1.
  - This overrides load-use, because the dependent instruction is squashed.
- **Load-use**, when not frozen, no branch, `ex_memRead`=1, `ex_RegAdd`≠0, and (`id_uses_rs1` and `ex_RegAdd`==`id_rs1`) or (`id_uses_rs2` and `ex_RegAdd`==`id_rs2`):
  - `pc_write`=0, `ifid_write`=0, `idex_bubble`=1;
  - `idex_write`=1, `exmem_write`=1.
- **Default:** all enables = 1; `ifid_flush`, `idex_bubble`, `memwb_bubble` = 0.
- **Timeout:** `wait_cnt` counts consecutive freeze cycles and is cleared on any non-freeze cycle.
  - When a freeze cycle occurs with `wait_cnt`==`TIMEOUT-1`, `mem_err` is set on the next edge.
  - `mem_err` stays set until `rst`. Freeze continues regardless of `mem_err`.
  - `wait_cnt` saturates at `TIMEOUT-1`.
- **Stall counter:** `stall_cnt` increments on each edge where `pc_write`=0 and `rst`=0. It saturates at all-ones and never wraps.

## Timing
- All control outputs are combinational from the current inputs, so they affect the same cycle's pipeline register update. Zero latency.
- `mem_err` and `stall_cnt` are registered, with one-cycle latency.
- **While `rst`=1**, outputs are forced regardless of the other inputs:
  - `pc_write`=0, `ifid_write`=0, `idex_write`=0, `exmem_write`=0;
  - `ifid_flush`=1, `idex_bubble`=1, `memwb_bubble`=1.
- **On the edge with `rst`=1**:
  - state←`RUN`, `wait_cnt`←0, `mem_err`←0, `stall_cnt`←0.
  - Reset in the middle of `MEM_WAIT` abandons the wait.
  - Reset cycles are not counted as stalls.
- **Load-use stall** lasts exactly one cycle per load. The load advances to MEM, and the dependency is then covered by forwarding.
- **Release cycle** (`mem_ready`=1): normal priority applies in that same cycle.

## Test plan
- **Load-use:** EX `lw x5`, ID `add x6,x5,x7` (`id_uses_rs1`=1) → one cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; next cycle defaults; `stall_cnt`=1.
- **x0 and unused source:** `ex_RegAdd`=0, or a match only on an unused rs2 → no stall, all enables 1.
- **Branch with load-use:** `ex_branch_taken`=1 while the load-use condition is true → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1; `stall_cnt` unchanged.
- **Memory wait:** `mem_req`=1 with `mem_ready` low for 3 cycles → 3 freeze cycles with `memwb_bubble`=1 and all enables 0; release on the 4th cycle; `stall_cnt`=3; `mem_err`=0.
- **Timeout:** `TIMEOUT`=4, `mem_ready` held low 6 cycles → `mem_err` rises after the 4th freeze edge and stays 1 after release, until `rst`.
- **Reset mid-wait:** `rst` pulsed during `MEM_WAIT` → outputs forced to reset values; the cycle after `rst` falls, with `mem_req`=0, all enables are 1 and `stall_cnt`=0.
